opblock_pipe: RTL

Parametrised, two-stage pipelined successor to the 6-instruction operational block. It accepts one command per cycle over a valid/ready handshake. Stage 1 (RD) reads register-file operands, with forwarding from stage 2. Stage 2 (EX) executes, drives the external data-memory port and writes back. The block also adds AND/OR, STORE, registered Z/C/N flags and a pipeline hold.

---
 rtl/opblock_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/opblock_pipe.sv
// Two-stage (RD/EX) pipelined operational block: register file with EX->RD
// forwarding, ALU with Z/C/N flags, external data-memory port and hold.
module opblock_pipe #(
    parameter int WIDTH     = 16,
    parameter int REGBITS   = 4,
    parameter int CONSTBITS = 8,
    parameter int MEMBITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [REGBITS-1:0]   cmd_wa,
    input  logic [REGBITS-1:0]   cmd_pa,
    input  logic [REGBITS-1:0]   cmd_qa,
    input  logic [CONSTBITS-1:0] cmd_const,
    input  logic                 hold,
    output logic [MEMBITS-1:0]   mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_wr,
    output logic                 mem_rd,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     result,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_n
);

    localparam int NREG = 2 ** REGBITS;

    typedef enum logic [2:0] {
        OP_STORE = 3'b000,
        OP_LOADC = 3'b001,
        OP_LOADM = 3'b010,
        OP_MOV   = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_AND   = 3'b110,
        OP_OR    = 3'b111
    } op_e;

    logic [WIDTH-1:0]     rf_q [NREG];
    logic                 ex_valid_q, ex_valid_d;
    op_e                  ex_op_q;
    logic [REGBITS-1:0]   ex_wa_q;
    logic [CONSTBITS-1:0] ex_const_q;
    logic [WIDTH-1:0]     ex_p_q, ex_q_q;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 flag_z_q, flag_c_q, flag_n_q;

    logic                 accept, ex_fire;
    logic [WIDTH-1:0]     ex_val, q_opnd, p_rd, q_rd;
    logic [WIDTH:0]       sum;
    logic                 ex_wr, ex_flags, sub_sel, c_new;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is simply ~hold, so the producer may hold cmd_valid across a stall.
    assign cmd_ready = ~hold;
    assign accept    = cmd_valid && cmd_ready;
    assign ex_fire   = ex_valid_q && !hold;

    // SUB is P + ~Q + 1, so carry-out doubles as "no borrow".
    assign sub_sel = (ex_op_q == OP_SUB);
    assign q_opnd  = sub_sel ? ~ex_q_q : ex_q_q;
    assign sum     = {1'b0, ex_p_q} + {1'b0, q_opnd} + {{WIDTH{1'b0}}, sub_sel};

    always_comb begin
        ex_val   = '0;
        ex_wr    = 1'b0;
        ex_flags = 1'b0;
        c_new    = 1'b0;
        case (ex_op_q)
            OP_STORE: ex_wr = 1'b0;
            OP_LOADC: begin ex_val = WIDTH'(ex_const_q); ex_wr = 1'b1; end
            OP_LOADM: begin ex_val = mem_rdata; ex_wr = 1'b1; end
            OP_MOV:   begin ex_val = ex_p_q; ex_wr = 1'b1; end
            OP_ADD, OP_SUB: begin
                ex_val = sum[WIDTH-1:0]; ex_wr = 1'b1; ex_flags = 1'b1; c_new = sum[WIDTH];
            end
            OP_AND:   begin ex_val = ex_p_q & ex_q_q; ex_wr = 1'b1; ex_flags = 1'b1; end
            OP_OR:    begin ex_val = ex_p_q | ex_q_q; ex_wr = 1'b1; ex_flags = 1'b1; end
            default:  ex_wr = 1'b0;
        endcase
    end

    // Operand read with forwarding of the value EX is about to write this edge.
    assign p_rd = (ex_valid_q && ex_wr && ex_wa_q == cmd_pa) ? ex_val : rf_q[cmd_pa];
    assign q_rd = (ex_valid_q && ex_wr && ex_wa_q == cmd_qa) ? ex_val : rf_q[cmd_qa];

    assign mem_addr  = ex_const_q[MEMBITS-1:0];
    assign mem_wdata = ex_p_q;
    assign mem_wr    = ex_fire && (ex_op_q == OP_STORE);
    assign mem_rd    = ex_fire && (ex_op_q == OP_LOADM);

    always_comb begin
        ex_valid_d     = hold ? ex_valid_q : accept;
        result_valid_d = ex_fire && ex_wr;
        result_d       = result_valid_d ? ex_val : result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flag_z_q       <= 1'b0;
            flag_c_q       <= 1'b0;
            flag_n_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            if (accept) begin
                ex_op_q    <= op_e'(cmd_op);
                ex_wa_q    <= cmd_wa;
                ex_const_q <= cmd_const;
                ex_p_q     <= p_rd;
                ex_q_q     <= q_rd;
            end
            if (result_valid_d) rf_q[ex_wa_q] <= ex_val;
            if (ex_fire && ex_flags) begin
                flag_z_q <= (ex_val == '0);
                flag_c_q <= c_new;
                flag_n_q <= ex_val[WIDTH-1];
            end
        end
    end

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;
    assign flag_n       = flag_n_q;

endmodule
